stopwatch_counter: RTL

Consumer of the divided stopwatch clock. It samples the 100 Hz square wave produced by the stopwatch clock divider in the system clock domain and converts each rising edge into a one-cycle tick. It runs a start/pause/clear state machine and counts elapsed time as BCD minutes, seconds and centiseconds (MM:SS.CC), which feed the seven-segment display mux.

---
 rtl/stopwatch_counter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: samples the 100 Hz stopwatch tick, runs the
// start/pause/clear state machine and counts elapsed time as BCD MM:SS.CC.
// Optional feature: define STOPWATCH_LAP_EN to build the lap (display
// freeze) snapshot; otherwise the lap input is ignored.
`timescale 1ns/1ps

module stopwatch_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       running,
  output logic       wrap
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     state, state_next;
  logic       sync0, sync1, sync2;
  logic       tick_p;
  logic       advance;
  logic [3:0] cs_ones_q, cs_tens_q, s_ones_q, s_tens_q, m_ones_q, m_tens_q;
  logic       inc_cs_tens, inc_s_ones, inc_s_tens, inc_m_ones, inc_m_tens;
  logic       rollover;
  logic [23:0] live;

  // Next value of one BCD digit that is being incremented.
  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Two-flop synchroniser for tick_in plus an edge flop for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync0 <= tick_in;
      sync1 <= sync0;
      sync2 <= sync1;
    end
  end

  assign tick_p = sync1 & ~sync2;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; clear wins over start_stop and over a pending tick.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    running    = (state == RUN);
    advance    = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start_stop) state_next = RUN;
        RUN: begin
          advance = tick_p;   // a tick alongside RUN->PAUSE still counts
          if (start_stop) state_next = PAUSE;
        end
        PAUSE:   if (start_stop) state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  // Ripple carry enables, least significant digit first.
  assign inc_cs_tens = advance     & (cs_ones_q == 4'd9);
  assign inc_s_ones  = inc_cs_tens & (cs_tens_q == 4'd9);
  assign inc_s_tens  = inc_s_ones  & (s_ones_q  == 4'd9);
  assign inc_m_ones  = inc_s_tens  & (s_tens_q  == 4'd5);
  assign inc_m_tens  = inc_m_ones  & (m_ones_q  == 4'd9);
  assign rollover    = inc_m_tens  & (m_tens_q  == 4'd5);

  // BCD counters and the one-cycle wrap pulse that marks 59:59.99 -> 00:00.00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_ones_q <= 4'd0;
      cs_tens_q <= 4'd0;
      s_ones_q  <= 4'd0;
      s_tens_q  <= 4'd0;
      m_ones_q  <= 4'd0;
      m_tens_q  <= 4'd0;
      wrap      <= 1'b0;
    end else if (clear) begin
      cs_ones_q <= 4'd0;
      cs_tens_q <= 4'd0;
      s_ones_q  <= 4'd0;
      s_tens_q  <= 4'd0;
      m_ones_q  <= 4'd0;
      m_tens_q  <= 4'd0;
      wrap      <= 1'b0;
    end else begin
      if (advance)     cs_ones_q <= bump(cs_ones_q, 4'd9);
      if (inc_cs_tens) cs_tens_q <= bump(cs_tens_q, 4'd9);
      if (inc_s_ones)  s_ones_q  <= bump(s_ones_q,  4'd9);
      if (inc_s_tens)  s_tens_q  <= bump(s_tens_q,  4'd5);
      if (inc_m_ones)  m_ones_q  <= bump(m_ones_q,  4'd9);
      if (inc_m_tens)  m_tens_q  <= bump(m_tens_q,  4'd5);
      wrap <= rollover;
    end
  end

  assign live = {m_tens_q, m_ones_q, s_tens_q, s_ones_q, cs_tens_q, cs_ones_q};

`ifdef STOPWATCH_LAP_EN
  logic        freeze;
  logic [23:0] snap;

  // Lap freeze: capture in RUN, release from RUN or PAUSE; ignored in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze <= 1'b0;
      snap   <= 24'd0;
    end else if (clear) begin
      freeze <= 1'b0;
    end else if (lap) begin
      if (freeze && (state == RUN || state == PAUSE)) begin
        freeze <= 1'b0;
      end else if (!freeze && state == RUN) begin
        freeze <= 1'b1;
        snap   <= live;
      end
    end
  end

  assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = freeze ? snap : live;
`else
  logic lap_unused;
  assign lap_unused = lap;

  assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = live;
`endif

endmodule
